// File: rtl/pe_weight_loader.sv
// Weight-tile loader for a ROWS x COLS mac_pe array: buffers one tile, then bursts it bottom row
// first. Define WLOAD_SHIFT_SAT_EN to clamp each stored weight's shift field to MAX_SHIFT.
module pe_weight_loader #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned W_W       = 8,
    parameter int unsigned SUM_W     = 32,
    parameter int unsigned MAX_SHIFT = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [COLS*W_W-1:0]   w_data,
    output logic                  load_weight_en,
    output logic [COLS*SUM_W-1:0] col_sum,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned RowW = COLS * W_W;
    localparam int unsigned CntW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CntW-1:0] LastRow = CntW'(ROWS - 1);
    localparam logic [3:0] MaxShift = 4'(MAX_SHIFT);
`ifdef WLOAD_SHIFT_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StFill, StBurst, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [RowW-1:0]        tile_q [ROWS];
    logic                   tile_we;
    logic [RowW-1:0]        wdata_sat;
    logic                   w_ready_q, w_ready_d;
    logic                   load_q, load_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [COLS*SUM_W-1:0]  col_sum_q, col_sum_d;

    function automatic logic [RowW-1:0] sat_row(input logic [RowW-1:0] row);
        logic [RowW-1:0] r;
        r = row;
        for (int c = 0; c < int'(COLS); c++) begin
            if (SatEn && (row[c*W_W+4 +: 4] > MaxShift)) begin
                r[c*W_W+4 +: 4] = MaxShift;
            end
        end
        return r;
    endfunction

    function automatic logic [COLS*SUM_W-1:0] expand(input logic [RowW-1:0] row);
        logic [COLS*SUM_W-1:0] s;
        s = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            s[c*SUM_W +: SUM_W] = SUM_W'(row[c*W_W +: W_W]);
        end
        return s;
    endfunction

    always_comb begin
        wdata_sat = sat_row(w_data);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tile_we   = 1'b0;
        w_ready_d = 1'b0;
        load_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        col_sum_d = '0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d   = StFill;
                    cnt_d     = '0;
                    w_ready_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            StFill: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    w_ready_d = 1'b1;
                    busy_d    = 1'b1;
                    if (w_valid && w_ready_q) begin
                        tile_we = 1'b1;
                        cnt_d   = cnt_q + CntW'(1);
                        // Last beat goes straight out as burst cycle 0 (bottom row first).
                        if (cnt_q == LastRow) begin
                            state_d   = StBurst;
                            cnt_d     = '0;
                            w_ready_d = 1'b0;
                            load_d    = 1'b1;
                            col_sum_d = expand(wdata_sat);
                        end
                    end
                end
            end
            StBurst: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == LastRow) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CntW'(1);
                    load_d    = 1'b1;
                    busy_d    = 1'b1;
                    col_sum_d = expand(tile_q[LastRow - cnt_q - CntW'(1)]);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            w_ready_q <= 1'b0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            col_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_ready_q <= w_ready_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            col_sum_q <= col_sum_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                tile_q[r] <= '0;
            end
        end else if (tile_we) begin
            tile_q[cnt_q] <= wdata_sat;
        end
    end

    assign w_ready        = w_ready_q;
    assign load_weight_en = load_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign col_sum        = col_sum_q;

endmodule

// File: tb/tb_pe_weight_loader.sv
// Bench for pe_weight_loader: transaction-level reference model checked every cycle,
// plus directed literal checks on burst order, timing, abort, saturation and async reset.
module tb_pe_weight_loader;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         w_valid = 1'b0;
    logic [31:0]  w_data = '0;
    logic         w_ready;
    logic         load_weight_en;
    logic [127:0] col_sum;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pe_weight_loader #(
        .ROWS(ROWS), .COLS(COLS), .W_W(8), .SUM_W(32), .MAX_SHIFT(11)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .load_weight_en(load_weight_en), .col_sum(col_sum), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic         load;
        logic         ready;
        logic         busy;
        logic         done;
        logic [127:0] sum;
    } out_t;

    out_t        exp_o = '0;
    out_t        sched[$];
    int          mode = 0;  // 0 idle, 1 collecting rows, 2 playing back schedule
    int          filled = 0;
    logic [31:0] tile[ROWS];

    function automatic logic [7:0] sat_w(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef WLOAD_SHIFT_SAT_EN
        if ((b >> 4) > 8'd11) r = {4'd11, b[3:0]};
`endif
        return r;
    endfunction

    function automatic logic [31:0] sat_row(input logic [31:0] row);
        logic [31:0] r;
        for (int c = 0; c < COLS; c++) r[c*8 +: 8] = sat_w(row[c*8 +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] expand(input logic [31:0] row);
        logic [127:0] s;
        for (int c = 0; c < COLS; c++) s[c*32 +: 32] = {24'd0, row[c*8 +: 8]};
        return s;
    endfunction

    task automatic model_step();
        out_t nx;
        out_t rec;
        nx = '0;
        if (!rst_n) begin
            mode = 0;
            filled = 0;
            sched.delete();
            exp_o = '0;
            return;
        end
        case (mode)
            0: if (start && !abort) begin
                mode = 1;
                filled = 0;
                nx.ready = 1'b1;
                nx.busy = 1'b1;
            end
            1: if (abort) begin
                mode = 0;
            end else begin
                if (w_valid) begin
                    tile[filled] = sat_row(w_data);
                    filled++;
                end
                if (filled == ROWS) begin
                    for (int k = 0; k < ROWS; k++) begin
                        rec = '0;
                        rec.load = 1'b1;
                        rec.busy = 1'b1;
                        rec.sum = expand(tile[ROWS-1-k]);
                        sched.push_back(rec);
                    end
                    rec = '0;
                    rec.done = 1'b1;
                    sched.push_back(rec);
                    nx = sched.pop_front();
                    mode = 2;
                end else begin
                    nx.ready = 1'b1;
                    nx.busy = 1'b1;
                end
            end
            default: if (abort && exp_o.load) begin
                sched.delete();
                mode = 0;
            end else if (sched.size() > 0) begin
                nx = sched.pop_front();
            end else begin
                mode = 0;
            end
        endcase
        exp_o = nx;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- per-cycle compare and logging ----------------
    typedef struct {
        int           c;
        logic [127:0] s;
    } burst_t;
    burst_t burst_log[$];
    int     done_log[$];

    initial forever begin
        @(negedge clk);
        checks++;
        if ({load_weight_en, w_ready, busy, done, col_sum} !== exp_o) begin
            errors++;
            $display("FAIL cycle %0d model: got le=%b rdy=%b busy=%b done=%b sum=%h, want le=%b rdy=%b busy=%b done=%b sum=%h",
                     cyc, load_weight_en, w_ready, busy, done, col_sum,
                     exp_o.load, exp_o.ready, exp_o.busy, exp_o.done, exp_o.sum);
        end
        if (load_weight_en) burst_log.push_back('{c: cyc, s: col_sum});
        if (done) done_log.push_back(cyc);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic a, input logic v, input logic [31:0] d);
        @(negedge clk);
        start = s;
        abort = a;
        w_valid = v;
        w_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    function automatic logic [31:0] test_row(input int r);
        logic [7:0] b;
        b = 8'h10 + 8'(r);
        return {b, b, b, b};
    endfunction

    // Feeds the 0x10.. tile; gap idle cycles inserted after beat index 1. Returns start cycle.
    task automatic feed_tile(input int gap, output int start_cyc);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        start_cyc = cyc;
        for (int r = 0; r < ROWS; r++) begin
            step(1'b0, 1'b0, 1'b1, test_row(r));
            if (r == 1) repeat (gap) step(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        end
    endtask

    task automatic check_burst(input string tag, input int start_cyc, input int first_off);
        logic [31:0] w;
        check({tag, " burst len"}, 128'(burst_log.size()), 128'(ROWS));
        if (burst_log.size() == ROWS) begin
            check({tag, " first burst cycle"}, 128'(burst_log[0].c - start_cyc), 128'(first_off));
            for (int k = 0; k < ROWS; k++) begin
                w = 32'h13 - 32'(k);
                check({tag, " burst data"}, burst_log[k].s, {w, w, w, w});
                check({tag, " burst contiguous"}, 128'(burst_log[k].c - burst_log[0].c), 128'(k));
            end
        end
        check({tag, " done count"}, 128'(done_log.size()), 128'd1);
        if (done_log.size() == 1)
            check({tag, " done cycle"}, 128'(done_log[0] - start_cyc), 128'(first_off + ROWS));
    endtask

    initial begin
        int sc;
        logic [31:0] row_sat;

        #1 rst_n = 1'b0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("reset load_weight_en", 128'(load_weight_en), 128'd0);
        check("reset col_sum", col_sum, 128'd0);
        check("reset w_ready", 128'(w_ready), 128'd0);
        check("reset done", 128'(done), 128'd0);

        // Back-to-back tile.
        burst_log.delete();
        done_log.delete();
        feed_tile(0, sc);
        idle(10);
        check_burst("b2b", sc, ROWS + 1);

        // Same tile with a 3-cycle valid gap: done slips by 3.
        burst_log.delete();
        done_log.delete();
        feed_tile(3, sc);
        idle(10);
        check_burst("gap", sc, ROWS + 4);

        // w_valid in idle and start during fill are both ignored.
        burst_log.delete();
        done_log.delete();
        repeat (3) step(1'b0, 1'b0, 1'b1, 32'hAAAA_AAAA);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        sc = cyc;
        step(1'b0, 1'b0, 1'b1, test_row(0));
        step(1'b0, 1'b0, 1'b1, test_row(1));
        step(1'b1, 1'b0, 1'b0, 32'h5555_5555);
        step(1'b0, 1'b0, 1'b1, test_row(2));
        step(1'b0, 1'b0, 1'b1, test_row(3));
        idle(10);
        check_burst("ignored", sc, ROWS + 2);

        // Abort in burst cycle 2, restart on the following cycle.
        burst_log.delete();
        done_log.delete();
        feed_tile(0, sc);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("abort load_weight_en", 128'(load_weight_en), 128'd0);
        check("abort col_sum", col_sum, 128'd0);
        check("abort busy", 128'(busy), 128'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("restart busy", 128'(busy), 128'd1);
        check("restart w_ready", 128'(w_ready), 128'd1);
        check("abort no done", 128'(done_log.size()), 128'd0);
        for (int r = 0; r < ROWS; r++) step(1'b0, 1'b0, 1'b1, $urandom());
        idle(8);

        // Shift saturation: row 0 emitted in the last burst cycle.
        burst_log.delete();
        done_log.delete();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h53F3_53F3);
        for (int r = 1; r < ROWS; r++) step(1'b0, 1'b0, 1'b1, 32'h0101_0101);
        idle(8);
`ifdef WLOAD_SHIFT_SAT_EN
        row_sat = 32'h53B3_53B3;
`else
        row_sat = 32'h53F3_53F3;
`endif
        check("sat burst len", 128'(burst_log.size()), 128'(ROWS));
        if (burst_log.size() == ROWS) check("sat row0", burst_log[ROWS-1].s, expand(row_sat));

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 1, $urandom());
        step(1'b0, 1'b1, 1'b0, 32'd0);
        idle(8);

        // Async reset mid-burst clears outputs without a clock edge.
        feed_tile(0, sc);
        idle(1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst load_weight_en", 128'(load_weight_en), 128'd0);
        check("async rst col_sum", col_sum, 128'd0);
        check("async rst busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
